// File: rtl/rsa_modexp.sv
// Iterative modular exponentiation (result = base^exponent mod modulus), right-to-left square-and-multiply
// with two bit-serial interleaved modular multipliers. Optional MODEXP_CONST_TIME_EN processes every exponent bit.
module rsa_modexp #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REDUCE = 3'd1;
    localparam logic [2:0] CHECK  = 3'd2;
    localparam logic [2:0] MULT   = 3'd3;
    localparam logic [2:0] UPDATE = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);
    localparam logic [CW-1:0] ALL_BITS  = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [2:0]       state;
    logic [WIDTH-1:0] exp_reg;
    logic [WIDTH-1:0] mod_reg;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] xp;
    logic [WIDTH-1:0] xs;
    logic [WIDTH+1:0] acc_p;
    logic [WIDTH+1:0] acc_s;
    logic [SW-1:0]    step;
    logic [CW-1:0]    bit_cnt;

    logic [WIDTH+1:0] acc_p_next;
    logic [WIDTH+1:0] acc_s_next;
    logic [WIDTH-1:0] y_p;
    logic             finished;

    // One MSB-first step of interleaved modular multiplication; acc < n on entry and exit.
    function automatic logic [WIDTH+1:0] mm_step(input logic [WIDTH+1:0] acc,
                                                 input logic             xbit,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] n);
        logic [WIDTH+1:0] a;
        logic [WIDTH+1:0] nn;
        nn = {2'b00, n};
        a  = acc << 1;
        if (a >= nn) a = a - nn;
        if (xbit) begin
            a = a + {2'b00, y};
            if (a >= nn) a = a - nn;
        end
        return a;
    endfunction

    // The P multiplier doubles as the base reducer: modmul(base, 1).
    assign y_p        = (state == REDUCE) ? ONE : b;
    assign acc_p_next = mm_step(acc_p, xp[WIDTH-1], y_p, mod_reg);
    assign acc_s_next = mm_step(acc_s, xs[WIDTH-1], b, mod_reg);

`ifdef MODEXP_CONST_TIME_EN
    assign finished = (bit_cnt == ALL_BITS);
`else
    // Exponent is exhausted once all its bits have shifted out; the counter term never fires first.
    assign finished = (exp_reg == '0) || (bit_cnt == ALL_BITS);
`endif

    assign busy = (state == REDUCE) || (state == CHECK) || (state == MULT) || (state == UPDATE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            exp_reg <= '0;
            mod_reg <= '0;
            r       <= '0;
            b       <= '0;
            xp      <= '0;
            xs      <= '0;
            acc_p   <= '0;
            acc_s   <= '0;
            step    <= '0;
            bit_cnt <= '0;
            err     <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_reg <= exponent;
                        mod_reg <= modulus;
                        xp      <= base;
                        if (modulus == '0) begin
                            err    <= 1'b1;
                            result <= '0;
                            state  <= DONE;
                        end else if (modulus == ONE) begin
                            err    <= 1'b0;
                            result <= '0;
                            state  <= DONE;
                        end else begin
                            err     <= 1'b0;
                            r       <= ONE;
                            bit_cnt <= '0;
                            acc_p   <= '0;
                            step    <= '0;
                            state   <= REDUCE;
                        end
                    end
                end
                REDUCE: begin
                    acc_p <= acc_p_next;
                    xp    <= xp << 1;
                    step  <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        b     <= acc_p_next[WIDTH-1:0];
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (finished) begin
                        result <= r;
                        state  <= DONE;
                    end else begin
                        xp    <= r;
                        xs    <= b;
                        acc_p <= '0;
                        acc_s <= '0;
                        step  <= '0;
                        state <= MULT;
                    end
                end
                MULT: begin
                    acc_p <= acc_p_next;
                    acc_s <= acc_s_next;
                    xp    <= xp << 1;
                    xs    <= xs << 1;
                    step  <= step + 1'b1;
                    if (step == LAST_STEP) state <= UPDATE;
                end
                UPDATE: begin
                    if (exp_reg[0]) r <= acc_p[WIDTH-1:0];
                    b       <= acc_s[WIDTH-1:0];
                    exp_reg <= exp_reg >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    state   <= CHECK;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed self-checking bench for rsa_modexp at WIDTH = 64.
module tb_rsa_modexp;

    localparam int WIDTH = 64;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exponent;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int errors = 0;

    rsa_modexp #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected done cycle for an exponent of bit length k.
    function automatic int lat(input int k);
`ifdef MODEXP_CONST_TIME_EN
        return (WIDTH + 1) * (WIDTH + 2);
`else
        return (k + 1) * (WIDTH + 2);
`endif
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts one request, optionally pokes start mid-run, then checks latency and outputs.
    task automatic run(input string tag, input logic [WIDTH-1:0] bb, input logic [WIDTH-1:0] ee,
                       input logic [WIDTH-1:0] mm, input logic [WIDTH-1:0] exp_res,
                       input logic exp_err, input int exp_lat, input int poke_at);
        int t;
        @(negedge clk);
        base = bb; exponent = ee; modulus = mm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 1;
        check({tag, "_busy_t1"}, {63'd0, busy}, {63'd0, (exp_lat > 1)});
        while (!done && t < 6000) begin
            if (t == poke_at) begin
                start = 1'b1; base = 64'd7; exponent = 64'd3; modulus = 64'd11;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(t), 64'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_result_held"}, result, exp_res);
    endtask

    initial begin
        int t;
        int saw_done;
        reset = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_result", result, 64'd0);
        reset = 1'b0;

        run("small", 64'd4, 64'd13, 64'd497, 64'd445, 1'b0, lat(4), -1);
        run("encrypt", 64'd65, 64'd17, 64'd3233, 64'd2790, 1'b0, lat(5), -1);
        run("decrypt", 64'd2790, 64'd2753, 64'd3233, 64'd65, 1'b0, lat(12), -1);
        run("reduce", 64'd5000, 64'd1, 64'd3233, 64'd1767, 1'b0, lat(1), -1);
        run("exp0", 64'd123, 64'd0, 64'd3233, 64'd1, 1'b0, lat(0), -1);
        run("mod0", 64'd9, 64'd5, 64'd0, 64'd0, 1'b1, 1, -1);
        run("mod1", 64'd9, 64'd5, 64'd1, 64'd0, 1'b0, 1, -1);
        run("err_clear", 64'd4, 64'd13, 64'd497, 64'd445, 1'b0, lat(4), -1);
        run("mid_start", 64'd65, 64'd17, 64'd3233, 64'd2790, 1'b0, lat(5), 100);

        // Abort a run with reset in cycle 100; no done may follow.
        @(negedge clk);
        base = 64'd2790; exponent = 64'd2753; modulus = 64'd3233; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 1;
        while (t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_result", result, 64'd0);
        saw_done = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1;
        end
        check("abort_quiet", 64'(saw_done), 64'd0);

        run("after_reset", 64'd4, 64'd13, 64'd497, 64'd445, 1'b0, lat(4), -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_modexp.md
# rsa_modexp

Iterative modular exponentiation engine computing result = base^exponent mod modulus. It sits directly downstream of the RSA key generator. It consumes the generated modulus and the public exponent e or private exponent d to encrypt or decrypt one message word per request. Internally it uses right-to-left square-and-multiply, with two bit-serial interleaved modular multipliers running in parallel.

## Interface
- WIDTH, 64, operand width; matches the key generator's 2×32-bit e/d outputs.

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; accepted only in IDLE
- base  in  WIDTH  message; any value, reduced mod modulus internally
- exponent  in  WIDTH  e or d
- modulus  in  WIDTH  n = p·q
- busy  out  1  high in REDUCE, CHECK, MULT and UPDATE
- done  out  1  one-cycle pulse when result is valid
- err  out  1  set with done when modulus == 0; held until next accept
- result  out  WIDTH  registered; held from done until the next accept

## Operation
- States: IDLE, REDUCE, CHECK, MULT, UPDATE, DONE.
- IDLE: on start, latch base, exponent and modulus into internal registers.
  - If modulus == 0: go to DONE with result = 0 and err = 1.
  - If modulus == 1: go to DONE with result = 0 and err = 0.
  - Otherwise: clear err, set r = 1, clear the bit counter, and go to REDUCE.
- REDUCE, WIDTH cycles: compute b = base mod n as modmul(base, 1), scanning base MSB first. Then go to CHECK.
- modmul(x, y), one x bit per cycle, MSB first:
  - acc = 2·acc; subtract n if acc ≥ n.
  - If the x bit is set: acc = acc + y; subtract n if acc ≥ n.
  - Intermediate width is WIDTH+2. All operands are < n, so no further reduction is needed.
- CHECK:
  - Without the macro: exp_reg == 0 → DONE; otherwise → MULT.
  - With the macro: bit counter == WIDTH → DONE; otherwise → MULT.
- MULT, WIDTH cycles: run two multipliers in parallel, P = modmul(r, b) and S = modmul(b, b).
- UPDATE, 1 cycle:
  - If exp_reg[0] is set, r = P.
  - b = S.
  - Shift exp_reg right by 1 and increment the bit counter.
  - Go to CHECK.
- DONE, 1 cycle: drive done = 1 and result = r (or the special-case value), then go to IDLE.
- start while not in IDLE is ignored. No queueing, and inputs are not re-sampled.
- Exponent 0 with n > 1 gives result = 1.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, result 0, all internal registers 0.
- Reset mid-operation aborts immediately with no done pulse and returns to IDLE next cycle.
- Cycle numbering: t = 0 is the accepting clock edge.
  - busy is high from t = 1.
  - done is high in cycle L = (k+1)·(WIDTH+2), where k = bit length of exponent (index of MSB + 1; k = 0 for exponent 0).
  - With the macro, k = WIDTH always.
  - For the modulus ≤ 1 special cases, done is at t = 1.
- busy and done are never high together. busy falls in the same cycle done rises.
- A new start is accepted in the cycle after done (IDLE).
- result changes only on the edge entering DONE and is stable otherwise.

## Configuration
- MODEXP_CONST_TIME_EN:
  - Defined: always process all WIDTH exponent bits and compute P every iteration. r is still written only when the exponent bit is 1. Latency is fixed at (WIDTH+1)·(WIDTH+2), which is 4290 cycles at WIDTH = 64, independent of d.
  - Undefined: terminate early when the remaining exponent is zero. Latency depends on exponent length.

## Test plan
- WIDTH = 64, base = 4, exponent = 13, modulus = 497 → result = 445, err = 0. Done at t = 330 without the macro, t = 4290 with it.
- RSA round trip, n = 3233:
  - Encrypt m = 65 with e = 17 → 2790, done at t = 396.
  - Decrypt 2790 with d = 2753 → 65, done at t = 858.
- base = 5000 (≥ n), exponent = 1, modulus = 3233 → result = 1767, confirming the REDUCE step.
- Edge cases:
  - exponent = 0, modulus = 3233 → result 1, done at t = 66.
  - modulus = 0 → result 0, err = 1, done at t = 1.
  - modulus = 1 → result 0, err = 0.
- Control:
  - start pulsed again mid-MULT → ignored; the first result is unchanged.
  - reset asserted at t = 100 → idle next cycle with busy 0 and no done.
  - A fresh start afterwards completes correctly.
